// File: rtl/alu_multiciclo.sv
// Multi-cycle execution ALU: registered single-cycle logic/arith ops, iterative MUL/DIV.
// Optional macro ALU_OVF_EN adds the signed-overflow output desbordamiento for ADD/SUB.
module alu_multiciclo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       sel_alu,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] resultado,
    output logic             cero,
    output logic             busy,
    output logic             done,
    output logic             div_cero
`ifdef ALU_OVF_EN
    ,
    output logic             desbordamiento
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StIter = 2'd1;
    localparam logic [1:0] StFin  = 2'd2;

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0100;
    localparam logic [3:0] OpSub = 4'b0101;
    localparam logic [3:0] OpMul = 4'b0110;
    localparam logic [3:0] OpDiv = 4'b0111;
    localparam logic [3:0] OpSlt = 4'b1000;
    localparam logic [3:0] OpNeq = 4'b1001;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // x: multiplicand (MUL) or dividend/quotient (DIV); y: multiplier or divisor
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    // Accumulator for MUL, partial remainder for DIV
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cero_q, cero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divz_q, divz_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] fixed_res;
    logic             slt;

    assign abs_a  = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    assign abs_b  = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
    assign sum    = op_a + op_b;
    assign diff   = op_a - op_b;
    assign slt    = $signed(op_a) < $signed(op_b);

    assign rem_sh    = {rem_q, x_q[WIDTH-1]};
    assign trial     = rem_sh - {1'b0, y_q};
    assign mag       = is_div_q ? x_q : rem_q;
    assign fixed_res = neg_q ? (~mag + 1'b1) : mag;

    always_comb begin
        alu_res = '0;
        case (sel_alu)
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpAdd:   alu_res = sum;
            OpSub:   alu_res = diff;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, slt};
            OpNeq:   alu_res = {{(WIDTH-1){1'b0}}, (op_a != op_b)};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    logic ovf_q, ovf_d;
    logic alu_ovf;

    always_comb begin
        alu_ovf = 1'b0;
        if (sel_alu == OpAdd) begin
            alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        end else if (sel_alu == OpSub) begin
            alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign desbordamiento = ovf_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        rem_d    = rem_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        res_d    = res_q;
        cero_d   = cero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        divz_d   = divz_q;
`ifdef ALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    if ((sel_alu == OpDiv) && (op_b == '0)) begin
                        res_d  = '1;
                        cero_d = 1'b0;
                        divz_d = 1'b1;
                        done_d = 1'b1;
`ifdef ALU_OVF_EN
                        ovf_d  = 1'b0;
`endif
                    end else if ((sel_alu == OpMul) || (sel_alu == OpDiv)) begin
                        x_d      = abs_a;
                        y_d      = abs_b;
                        rem_d    = '0;
                        neg_d    = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        is_div_d = (sel_alu == OpDiv);
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = StIter;
                    end else begin
                        res_d  = alu_res;
                        cero_d = (alu_res == '0);
                        divz_d = 1'b0;
                        done_d = 1'b1;
`ifdef ALU_OVF_EN
                        ovf_d  = alu_ovf;
`endif
                    end
                end
            end
            StIter: begin
                if (is_div_q) begin
                    // Restoring division step: keep the subtraction only if it did not borrow
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        x_d   = {x_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH-1:0];
                        x_d   = {x_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    rem_d = rem_q + (y_q[0] ? x_q : '0);
                    x_d   = {x_q[WIDTH-2:0], 1'b0};
                    y_d   = {1'b0, y_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                res_d   = fixed_res;
                cero_d  = (fixed_res == '0);
                divz_d  = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
`ifdef ALU_OVF_EN
                ovf_d   = 1'b0;
`endif
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            rem_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            cero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rem_q    <= rem_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            res_q    <= res_d;
            cero_q   <= cero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            divz_q   <= divz_d;
        end
    end

    assign resultado = res_q;
    assign cero      = cero_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_cero  = divz_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo (WIDTH=32) against an arithmetic reference model.
module tb_alu_multiciclo;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   sel_alu;
    logic [W-1:0] op_a, op_b;
    logic [W-1:0] resultado;
    logic         cero, busy, done, div_cero;
`ifdef ALU_OVF_EN
    logic         desbordamiento;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    alu_multiciclo #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel_alu   (sel_alu),
        .op_a      (op_a),
        .op_b      (op_b),
        .resultado (resultado),
        .cero      (cero),
        .busy      (busy),
        .done      (done),
        .div_cero  (div_cero)
`ifdef ALU_OVF_EN
        ,
        .desbordamiento (desbordamiento)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_res(input logic [3:0] s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (s)
            4'd0: r = longint'(a & b);
            4'd1: r = longint'(a | b);
            4'd4: r = sa + sb;
            4'd5: r = sa - sb;
            4'd6: r = sa * sb;
            4'd7: r = (sb == 0) ? -1 : sa / sb;
            4'd8: r = (sa < sb) ? 1 : 0;
            4'd9: r = (a != b) ? 1 : 0;
            default: r = 0;
        endcase
        return r[W-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [3:0] s, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s == 4'd4)      r = sa + sb;
        else if (s == 4'd5) r = sa - sb;
        else                return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sel_alu = 4'd0; op_a = '0; op_b = '0;
        #12;
        tests_run++;
        if (resultado !== '0 || cero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            div_cero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: res=%h cero=%b busy=%b done=%b dz=%b, want 0/1/0/0/0",
                     resultado, cero, busy, done, div_cero);
        end
`ifdef ALU_OVF_EN
        tests_run++;
        if (desbordamiento !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ovf: got %b want 0", desbordamiento);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_cycle();
        logic [3:0]   codes [14] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8, 4'd9, 4'd2, 4'd3,
                                     4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        logic [3:0]   dsel [6] = '{4'd4, 4'd8, 4'd9, 4'd15, 4'd5, 4'd1};
        logic [W-1:0] da   [6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h1234,
                                   32'h8000_0000, 32'h0};
        logic [W-1:0] db   [6] = '{32'd1, 32'd1, 32'd5, 32'h5678, 32'd1, 32'h0};
        logic [W-1:0] exp;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i < 6) begin
                sel_alu = dsel[i]; op_a = da[i]; op_b = db[i];
            end else begin
                sel_alu = codes[$urandom_range(13, 0)];
                op_a = $urandom;
                op_b = ($urandom_range(3, 0) == 0) ? op_a : $urandom;
            end
            start = 1'b1;
            exp = ref_res(sel_alu, op_a, op_b);
            @(posedge clk);
            #1;
            start = 1'b0;
            tests_run++;
            if (done !== 1'b1 || busy !== 1'b0 || resultado !== exp || cero !== (exp == '0) ||
                div_cero !== 1'b0) begin
                tests_failed++;
                $display("FAIL single sel=%b a=%h b=%h: res=%h cero=%b done=%b busy=%b dz=%b, want res=%h cero=%b done=1 busy=0 dz=0",
                         sel_alu, op_a, op_b, resultado, cero, done, busy, div_cero,
                         exp, (exp == '0));
            end
`ifdef ALU_OVF_EN
            tests_run++;
            if (desbordamiento !== ref_ovf(sel_alu, op_a, op_b)) begin
                tests_failed++;
                $display("FAIL single_ovf sel=%b a=%h b=%h: got %b want %b", sel_alu, op_a,
                         op_b, desbordamiento, ref_ovf(sel_alu, op_a, op_b));
            end
`endif
            @(posedge clk);
            #1;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || resultado !== exp) begin
                tests_failed++;
                $display("FAIL single_hold: done=%b busy=%b res=%h, want done=0 busy=0 res=%h",
                         done, busy, resultado, exp);
            end
        end
    endtask

    task automatic test_iterative();
        logic [3:0]   dsel [4] = '{4'd6, 4'd7, 4'd7, 4'd6};
        logic [W-1:0] da   [4] = '{32'd7, 32'hFFFF_FFEC, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0] db   [4] = '{32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] exp;
        int n, busy_cnt;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i < 4) begin
                sel_alu = dsel[i]; op_a = da[i]; op_b = db[i];
            end else begin
                sel_alu = ($urandom_range(1, 0) == 0) ? 4'd6 : 4'd7;
                op_a = $urandom;
                op_b = ($urandom_range(1, 0) == 0) ? $urandom : $urandom_range(100, 1);
                if (op_b == '0) op_b = 32'd9;
                if ($urandom_range(1, 0) == 0) op_b = -op_b;
            end
            start = 1'b1;
            exp = ref_res(sel_alu, op_a, op_b);
            @(posedge clk);
            #1;
            start = 1'b0;
            // Scramble inputs: the DUT must work from its latched operands
            sel_alu = 4'($urandom); op_a = $urandom; op_b = $urandom;
            busy_cnt = busy ? 1 : 0;
            n = 0;
            while (done !== 1'b1 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
                if (busy === 1'b1) busy_cnt++;
            end
            tests_run++;
            if (n !== 33 || busy_cnt !== 33 || busy !== 1'b0 || resultado !== exp ||
                cero !== (exp == '0) || div_cero !== 1'b0) begin
                tests_failed++;
                $display("FAIL iter #%0d: edges=%0d busycyc=%0d busy=%b res=%h cero=%b dz=%b, want edges=33 busycyc=33 busy=0 res=%h cero=%b dz=0",
                         i, n, busy_cnt, busy, resultado, cero, div_cero, exp, (exp == '0));
            end
`ifdef ALU_OVF_EN
            tests_run++;
            if (desbordamiento !== 1'b0) begin
                tests_failed++;
                $display("FAIL iter_ovf #%0d: got %b want 0", i, desbordamiento);
            end
`endif
            @(posedge clk);
            #1;
            tests_run++;
            if (done !== 1'b0 || resultado !== exp) begin
                tests_failed++;
                $display("FAIL iter_done_drop #%0d: done=%b res=%h, want done=0 res=%h", i,
                         done, resultado, exp);
            end
        end
    endtask

    task automatic test_div_zero();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sel_alu = 4'd7;
            op_a = (i == 0) ? 32'd5 : $urandom;
            op_b = '0;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            tests_run++;
            if (done !== 1'b1 || busy !== 1'b0 || resultado !== 32'hFFFF_FFFF ||
                div_cero !== 1'b1 || cero !== 1'b0) begin
                tests_failed++;
                $display("FAIL divzero a=%h: done=%b busy=%b res=%h dz=%b cero=%b, want 1/0/ffffffff/1/0",
                         op_a, done, busy, resultado, div_cero, cero);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || div_cero !== 1'b1) begin
                tests_failed++;
                $display("FAIL divzero_hold: done=%b busy=%b dz=%b, want 0/0/1", done, busy,
                         div_cero);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] exp;
        int n;
        @(negedge clk);
        sel_alu = 4'd6; op_a = 32'd12345; op_b = 32'hFFFF_FFB3;
        exp = ref_res(4'd6, op_a, op_b);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        repeat (9) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        sel_alu = 4'd7; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        n++;
        start = 1'b0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (n !== 33 || resultado !== exp || div_cero !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start: edges=%0d res=%h dz=%b, want edges=33 res=%h dz=0", n,
                     resultado, div_cero, exp);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_start_idle: busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp1, exp2;
        int n;
        @(negedge clk);
        sel_alu = 4'd6; op_a = $urandom; op_b = $urandom;
        exp1 = ref_res(4'd6, op_a, op_b);
        start = 1'b1;
        n = 0;
        @(posedge clk);
        #1;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (n !== 33 || busy !== 1'b0 || resultado !== exp1) begin
            tests_failed++;
            $display("FAIL b2b_first: edges=%0d busy=%b res=%h, want edges=33 busy=0 res=%h", n,
                     busy, resultado, exp1);
        end
        // start still high: accepted on this edge from IDLE, with fresh operands
        sel_alu = 4'd7; op_a = $urandom; op_b = $urandom_range(5000, 1);
        exp2 = ref_res(4'd7, op_a, op_b);
        @(posedge clk);
        #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", busy, done);
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (n !== 33 || resultado !== exp2) begin
            tests_failed++;
            $display("FAIL b2b_second: edges=%0d res=%h, want edges=33 res=%h", n, resultado,
                     exp2);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        @(negedge clk);
        sel_alu = 4'd6; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || resultado !== '0 || cero !== 1'b1 || done !== 1'b0 ||
            div_cero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b res=%h cero=%b done=%b dz=%b, want 0/0/1/0/0",
                     busy, resultado, cero, done, div_cero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen !== 0 || resultado !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_abort: done/busy cycles=%0d res=%h, want 0 and 0",
                     done_seen, resultado);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_cycle();
        test_div_zero();
        test_iterative();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Execution-stage ALU that consumes the 4-bit operation select produced by the ALU control decoder.
- Performs AND, OR, ADD, SUB and SLT as registered single-cycle operations, plus a not-equal compare.
- Performs MUL and DIV iteratively over WIDTH cycles, using a start/busy/done handshake so the pipeline control can stall.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request operation; sampled only in IDLE.
- sel_alu  in  4  operation select (encoding below).
- op_a  in  WIDTH  operand A, two's complement.
- op_b  in  WIDTH  operand B, two's complement.
- resultado  out  WIDTH  registered result.
- cero  out  1  registered flag, resultado == 0.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse, result valid.
- div_cero  out  1  last completed op was DIV with op_b == 0.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: resultado=0, cero=1, busy=0, done=0, div_cero=0, FSM=IDLE, iteration counter=0.
- Reset mid-operation aborts immediately; no done is produced.
- sel_alu encoding:
  - 0000 AND, 0001 OR
  - 0100 ADD, 0101 SUB (both wrap modulo 2^WIDTH)
  - 0110 MUL (low WIDTH bits of signed product)
  - 0111 DIV (signed quotient, truncated toward zero)
  - 1000 SLT (signed; 1 if a<b, else 0)
  - 1001 NEQ (1 if a!=b, else 0)
  - any other code: result 0.
- FSM states: IDLE, ITER, FIN.
- Single-cycle ops and undefined codes:
  - start=1 in IDLE at edge k.
  - resultado, cero, div_cero=0 and done=1 update at edge k; FSM stays in IDLE.
- MUL/DIV:
  - At edge k (IDLE, start=1): latch |a|, |b| and the result sign; counter=0; busy=1; go to ITER.
  - ITER performs one shift-add (MUL) or restoring-subtract (DIV) step per edge, over edges k+1..k+WIDTH.
  - After the WIDTH-th step, go to FIN.
  - At edge k+WIDTH+1: apply sign fix; write resultado and cero; done=1; busy=0; return to IDLE.
  - done is therefore visible in the cycle after edge k+WIDTH+1.
- Divide by zero:
  - Not iterated.
  - At edge k: resultado = all ones, div_cero=1, done=1, busy stays 0.
- Overflow cases:
  - DIV of most-negative by -1 returns the most-negative value, no flag.
  - MUL overflow is silently truncated.
- start while busy=1 is ignored, and operands are not re-sampled.
- done returns to 0 the cycle after its pulse.
- A start in the same cycle as done's return to IDLE is accepted on the following edge only (FIN does not accept start).
- resultado, cero and div_cero hold their values until the next completed operation.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined: adds output port desbordamiento (1 bit, reset 0).
  - Registered with resultado.
  - Set to 1 on signed overflow of ADD or SUB; 0 for every other operation.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF, b=1, start one cycle -> resultado=0x80000000, done pulse next cycle, busy never 1; with ALU_OVF_EN, desbordamiento=1.
- MUL a=7, b=-3 -> busy high 33 cycles, resultado=0xFFFFFFEB, done one cycle at edge k+33, cero=0.
- DIV a=-20, b=3 -> resultado=0xFFFFFFFA after 33 edges; then DIV a=5, b=0 -> resultado=0xFFFFFFFF, div_cero=1, done at edge k, busy=0.
- SLT a=-1, b=1 -> 1; NEQ a=5, b=5 -> resultado=0, cero=1; sel_alu=1111 -> resultado=0, done pulse.
- MUL started, new start with DIV operands asserted at cycle 10 -> ignored, MUL result unchanged; rst_n low at cycle 20 -> busy=0, resultado=0, cero=1 immediately, no done.
